// File: rtl/div_u27_u21_stream_pkg.sv
// Shared constants for the div_u27_u21 stream adapter: default widths,
// core latency, output FIFO depth and the divide-by-zero quotient.
// Optional feature macro: DIV_STREAM_TAG_EN (adds a per-op tag carried to the output).
package div_u27_u21_stream_pkg;

    localparam int unsigned DIV_WIDTHN  = 27;
    localparam int unsigned DIV_WIDTHD  = 21;
    localparam int unsigned DIV_LATENCY = 4;
    localparam int unsigned DIV_DEPTH   = 8;
    localparam int unsigned DIV_TAG_W   = 8;

    // Quotient reported for a zero divisor.
    localparam logic [DIV_WIDTHN-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/div_u27_u21_stream_if.sv
// Operand/result stream bundle between a producer/consumer (master) and the
// divider stream adapter (slave).
// Optional feature macro: DIV_STREAM_TAG_EN (adds in_tag/out_tag).
interface div_u27_u21_stream_if
    import div_u27_u21_stream_pkg::*;
#(
    parameter int unsigned WIDTHN = DIV_WIDTHN,
    parameter int unsigned WIDTHD = DIV_WIDTHD
`ifdef DIV_STREAM_TAG_EN
    , parameter int unsigned TAG_W = DIV_TAG_W
`endif
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTHN-1:0] in_numer;
    logic [WIDTHD-1:0] in_denom;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTHN-1:0] out_quot;
    logic [WIDTHD-1:0] out_rem;
    logic              out_dz;
`ifdef DIV_STREAM_TAG_EN
    logic [TAG_W-1:0]  in_tag;
    logic [TAG_W-1:0]  out_tag;
`endif

    modport master (
`ifdef DIV_STREAM_TAG_EN
        output in_tag,
        input  out_tag,
`endif
        output in_valid, in_numer, in_denom, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_dz
    );

    modport slave (
`ifdef DIV_STREAM_TAG_EN
        input  in_tag,
        output out_tag,
`endif
        input  in_valid, in_numer, in_denom, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_dz
    );

endinterface

// File: rtl/div_u27_u21_stream_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered write.
// A push on a full FIFO is accepted only together with a pop.
module div_result_fifo #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Head word is visible whenever the FIFO holds data, zero otherwise.
    assign pop_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/div_u27_u21_stream.sv
// Valid/ready adapter around the clken-pipelined divider core div_u27_u21.
// Tracks in-flight ops with a valid shift chain and reserves an output FIFO
// slot per accepted op so the core never has to stall.
// Optional feature macro: DIV_STREAM_TAG_EN (tag travels with each op).
module div_u27_u21_stream
    import div_u27_u21_stream_pkg::*;
#(
    parameter int unsigned WIDTHN  = DIV_WIDTHN,
    parameter int unsigned WIDTHD  = DIV_WIDTHD,
    parameter int unsigned LATENCY = DIV_LATENCY,
    parameter int unsigned DEPTH   = DIV_DEPTH
`ifdef DIV_STREAM_TAG_EN
    , parameter int unsigned TAG_W = DIV_TAG_W
`endif
) (
    input  logic               clk,
    input  logic               reset,
    div_u27_u21_stream_if.slave s,
    output logic [WIDTHN-1:0]  div_numer,
    output logic [WIDTHD-1:0]  div_denom,
    output logic               div_clken,
    input  logic [WIDTHN-1:0]  div_quot,
    input  logic [WIDTHD-1:0]  div_rem
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned RES_W = WIDTHN + WIDTHD + 1;
`ifdef DIV_STREAM_TAG_EN
    localparam int unsigned PAY_W = RES_W + TAG_W;
`else
    localparam int unsigned PAY_W = RES_W;
`endif

    logic [LATENCY:1]  vpipe_q, vpipe_d;
    logic [LATENCY:1]  dzpipe_q, dzpipe_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  fifo_count;
    logic              in_ready_c, fire, pop, push, denom_zero;
    logic [RES_W-1:0]  push_res;
    logic [PAY_W-1:0]  push_data, pop_data;

    assign denom_zero = (s.in_denom == '0);
    assign in_ready_c = (occ_q < OCC_W'(DEPTH)) & ~reset;
    assign fire       = s.in_valid & in_ready_c;
    assign pop        = s.out_valid & s.out_ready;
    assign push       = vpipe_q[LATENCY];

    assign s.in_ready = in_ready_c;
    assign s.out_valid = (fifo_count != '0);

    // Core feed: a zero divisor is replaced by 1 and flagged in dzpipe instead.
    assign div_numer = s.in_numer;
    assign div_denom = denom_zero ? WIDTHD'(1) : s.in_denom;
    assign div_clken = (fire | (vpipe_q != '0)) & ~reset;

    // Next-state for the in-flight tracker and the credit counter.
    always_comb begin
        vpipe_d  = vpipe_q;
        dzpipe_d = dzpipe_q;
        occ_d    = occ_q + OCC_W'(fire) - OCC_W'(pop);
        if (div_clken) begin
            vpipe_d[1]  = fire;
            dzpipe_d[1] = fire & denom_zero;
            for (int i = 2; i <= int'(LATENCY); i++) begin
                vpipe_d[i]  = vpipe_q[i-1];
                dzpipe_d[i] = dzpipe_q[i-1];
            end
        end
    end

    // Tracker and credit state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe_q  <= '0;
            dzpipe_q <= '0;
            occ_q    <= '0;
        end else begin
            vpipe_q  <= vpipe_d;
            dzpipe_q <= dzpipe_d;
            occ_q    <= occ_d;
        end
    end

    // Result word pushed when the tracked op leaves the core.
    always_comb begin
        push_res = {div_quot, div_rem, 1'b0};
        if (dzpipe_q[LATENCY]) push_res = {{WIDTHN{1'b1}}, {WIDTHD{1'b0}}, 1'b1};
    end

`ifdef DIV_STREAM_TAG_EN
    logic [TAG_W-1:0] tagpipe_q [1:LATENCY];

    // Tag rides alongside the valid chain; no reset needed since vpipe qualifies it.
    always_ff @(posedge clk) begin
        if (div_clken) begin
            tagpipe_q[1] <= s.in_tag;
            for (int i = 2; i <= int'(LATENCY); i++) tagpipe_q[i] <= tagpipe_q[i-1];
        end
    end

    assign push_data = {push_res, tagpipe_q[LATENCY]};
    assign {s.out_quot, s.out_rem, s.out_dz, s.out_tag} = pop_data;
`else
    assign push_data = push_res;
    assign {s.out_quot, s.out_rem, s.out_dz} = pop_data;
`endif

    div_result_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (pop_data),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_div_u27_u21_stream.sv
// Bench for div_u27_u21_stream: behavioural core model, queue-based
// scoreboard of expected results, directed and random valid/ready traffic.
module tb_div_u27_u21_stream;
    import div_u27_u21_stream_pkg::*;

    localparam int unsigned WN  = 27;
    localparam int unsigned WD  = 21;
    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 8;

    typedef struct packed {
        logic [WN-1:0] q;
        logic [WD-1:0] r;
        logic          dz;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_u27_u21_stream_if #(.WIDTHN(WN), .WIDTHD(WD)) bus ();

    logic [WN-1:0] div_numer, div_quot;
    logic [WD-1:0] div_denom, div_rem;
    logic          div_clken;

    div_u27_u21_stream #(
        .WIDTHN(WN), .WIDTHD(WD), .LATENCY(LAT), .DEPTH(DEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (bus),
        .div_numer (div_numer),
        .div_denom (div_denom),
        .div_clken (div_clken),
        .div_quot  (div_quot),
        .div_rem   (div_rem)
    );

    // Behavioural pipelined core: LAT stages that advance only on clken.
    logic [WN-1:0] core_q [LAT];
    logic [WD-1:0] core_r [LAT];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LAT); i++) begin
                core_q[i] <= '0;
                core_r[i] <= '0;
            end
        end else if (div_clken) begin
            core_q[0] <= (div_denom == '0) ? '0 : div_numer / WN'(div_denom);
            core_r[0] <= (div_denom == '0) ? '0 : WD'(div_numer % WN'(div_denom));
            for (int i = 1; i < int'(LAT); i++) begin
                core_q[i] <= core_q[i-1];
                core_r[i] <= core_r[i-1];
            end
        end
    end
    assign div_quot = core_q[LAT-1];
    assign div_rem  = core_r[LAT-1];

    // Watch for a result pushed into a full FIFO with no simultaneous pop.
    logic viol = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(dut.push && dut.fifo_count == 4'(DEP) && !dut.pop))
            else begin
                viol <= 1'b1;
                $error("FAIL push_when_full observed=1 expected=0");
            end
        end
    end

    int   total = 0;
    int   bad   = 0;
    logic last_fire, last_pop;
    res_t exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t ref_div(input logic [WN-1:0] n, input logic [WD-1:0] d);
        res_t r;
        if (d == '0) begin
            r.q = DZ_QUOT; r.r = '0; r.dz = 1'b1;
        end else begin
            r.q = n / WN'(d); r.r = WD'(n % WN'(d)); r.dz = 1'b0;
        end
        return r;
    endfunction

    // One clock cycle: drive inputs at the falling edge, score, then advance.
    task automatic step(input logic v, input logic [WN-1:0] n, input logic [WD-1:0] d,
                        input logic rdy);
        res_t e;
        bus.in_valid  = v;
        bus.in_numer  = n;
        bus.in_denom  = d;
        bus.out_ready = rdy;
        #1;
        last_fire = v & bus.in_ready;
        last_pop  = bus.out_valid & rdy;
        if (last_pop) begin
            if (exp_q.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
            else begin
                e = exp_q.pop_front();
                chk("quot", 64'(bus.out_quot), 64'(e.q));
                chk("rem",  64'(bus.out_rem),  64'(e.r));
                chk("dz",   64'(bus.out_dz),   64'(e.dz));
            end
        end
        if (last_fire) begin
            chk("core_numer", 64'(div_numer), 64'(n));
            chk("core_denom", 64'(div_denom), (d == '0) ? 64'd1 : 64'(d));
            exp_q.push_back(ref_div(n, d));
        end
        if (!reset && !last_fire && exp_q.size() == 0) chk("clken_idle", 64'(div_clken), 64'(0));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1'b0, '0, '0, 1'b1);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!bus.out_valid && n < 40) begin
            step(1'b0, '0, '0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n, acc, fired, cyc;
        logic [WD-1:0] d;
        bus.in_valid = 1'b0; bus.in_numer = '0; bus.in_denom = '0; bus.out_ready = 1'b0;

        // Reset state.
        @(posedge clk); @(negedge clk); #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_quot",  64'(bus.out_quot),  64'(0));
        chk("rst_out_rem",   64'(bus.out_rem),   64'(0));
        chk("rst_out_dz",    64'(bus.out_dz),    64'(0));
        chk("rst_clken",     64'(div_clken),     64'(0));
        @(negedge clk);
        reset = 1'b0; #1;
        chk("ready_after_reset", 64'(bus.in_ready), 64'(1));
        @(negedge clk);

        // Single op 8/3 and its latency.
        step(1'b1, 27'd8, 21'd3, 1'b0);
        chk("single_fire", 64'(last_fire), 64'(1));
        wait_valid(n);
        chk("single_latency", 64'(n), 64'(LAT + 1));
        chk("single_quot", 64'(bus.out_quot), 64'(2));
        chk("single_rem",  64'(bus.out_rem),  64'(2));
        chk("single_dz",   64'(bus.out_dz),   64'(0));
        step(1'b0, '0, '0, 1'b1);

        // Extremes and divide by zero, back to back.
        step(1'b1, 27'h7FFFFFF, 21'h1FFFFF, 1'b1);
        step(1'b1, 27'd15, 21'h1FFFFF, 1'b1);
        step(1'b1, 27'd100, 21'd0, 1'b1);
        drain();

        // Divide by zero seen at the output with explicit constants.
        step(1'b1, 27'd100, 21'd0, 1'b0);
        wait_valid(n);
        chk("dz_quot", 64'(bus.out_quot), 64'h7FFFFFF);
        chk("dz_rem",  64'(bus.out_rem),  64'(0));
        chk("dz_flag", 64'(bus.out_dz),   64'(1));
        drain();

        // Back-pressure: 10 requests with the sink stalled.
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) chk("ready_low_9th", 64'(bus.in_ready), 64'(0));
            step(1'b1, 27'($urandom), 21'($urandom_range(1, 21'h1FFFFF)), 1'b0);
            if (last_fire) acc++;
        end
        chk("accepted", 64'(acc), 64'(8));
        #1;
        chk("bp_ready_at_pop", 64'(bus.in_ready), 64'(0));
        step(1'b0, '0, '0, 1'b1);
        chk("bp_first_pop", 64'(last_pop), 64'(1));
        #1;
        chk("bp_ready_after_pop", 64'(bus.in_ready), 64'(1));
        drain();

        // Reset with 3 ops in flight and 2 buffered.
        for (int i = 0; i < 5; i++) step(1'b1, 27'($urandom), 21'($urandom_range(1, 50)), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        chk("pre_reset_valid", 64'(bus.out_valid), 64'(1));
        chk("pre_reset_count", 64'(dut.fifo_count), 64'(2));
        reset = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("post_reset_valid", 64'(bus.out_valid), 64'(0));
        chk("post_reset_ready", 64'(bus.in_ready),  64'(1));
        for (int i = 0; i < 12; i++) step(1'b0, '0, '0, 1'b1);
        step(1'b1, 27'd9, 21'd4, 1'b0);
        wait_valid(n);
        chk("after_reset_quot", 64'(bus.out_quot), 64'(2));
        chk("after_reset_rem",  64'(bus.out_rem),  64'(1));
        drain();

        // Random traffic against the reference model.
        fired = 0;
        cyc   = 0;
        while (fired < 10000 && cyc < 60000) begin
            case ($urandom_range(0, 7))
                0:       d = '0;
                1:       d = 21'($urandom_range(1, 15));
                default: d = 21'($urandom);
            endcase
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? 27'($urandom_range(0, 255)) : 27'($urandom),
                 d, $urandom_range(0, 2) != 0);
            if (last_fire) fired++;
            cyc++;
        end
        chk("random_ops", 64'(fired), 64'(10000));
        drain();
        step(1'b0, '0, '0, 1'b1);
        chk("no_push_when_full", 64'(viol), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
